ram_delay_line_ctrl: RTL
========================

// Module: ram_delay_line_ctrl
// PURPOSE
//  Address/enable sequencer for a simple-dual-port BRAM used as a runtime-configurable delay line.
//  Sits between the pixel stream and the BRAM primitive in the SGM cost pipeline.
//  Turns a delay setting into circular write/read addresses, tracks fill state, and flags valid output,
//  so that data_out equals data_in delayed by exactly cfg_delay ce-cycles.
// PARAMETERS
//  ADDR_WIDTH  10    BRAM address width; buffer depth is 2**ADDR_WIDTH
//  MAX_DELAY   1024  largest accepted cfg_delay; must be <= 2**ADDR_WIDTH + RD_LATENCY
//  RD_LATENCY  1     BRAM read latency in ce-cycles; legal values are 1 or 2
// PORTS
//  clk        in   1             clock; all logic on rising edge
//  rst        in   1             synchronous, active-high reset
//  ce         in   1             stream advance; one sample is written per ce-cycle
//  cfg_delay  in   ADDR_WIDTH+1  requested delay, in ce-cycles
//  cfg_load   in   1             one-cycle strobe; latches cfg_delay and restarts the line
//  cfg_err    out  1             one-cycle pulse: cfg_delay out of range, load ignored
//  mem_we     out  1             BRAM write enable
//  mem_waddr  out  ADDR_WIDTH    BRAM write address
//  mem_wzero  out  1             BRAM write-data mux select: write 0 instead of data_in
//  mem_re     out  1             BRAM read/port enable; equals ce
//  mem_raddr  out  ADDR_WIDTH    BRAM read address
//  out_valid  out  1             BRAM output (data_out) is a valid delayed sample
//  busy       out  1             high while in the CLEAR or FILL state
// BEHAVIOUR
//  Reset: state=IDLE. mem_we, mem_wzero, out_valid, busy and cfg_err are 0. wptr, fill_cnt and L are 0.
//  Legal range: RD_LATENCY+2 <= cfg_delay <= MAX_DELAY. Otherwise cfg_err=1 for one cycle and all state is unchanged.
//  Ring length: L = cfg_delay - RD_LATENCY. This is latched on a legal cfg_load.
//  Addressing:
//   - mem_waddr = mem_raddr = wptr, combinational.
//   - The BRAM is READ_FIRST, so the read returns the sample written L ce-cycles earlier.
//  Pointer update (FILL/RUN, ce=1): wptr <= (wptr == L-1) ? 0 : wptr+1. wptr never reaches L.
//  Latency: a sample on data_in at ce-cycle t appears on data_out at ce-cycle t + cfg_delay.
//  Gating: ce=0 freezes wptr, fill_cnt, state and the out_valid pipeline. mem_we=0 while ce=0.
//  States:
//   - IDLE: mem_we=0. A legal cfg_load moves to CLEAR if the macro is defined, else to FILL.
//   - CLEAR: ignores ce; writes one location per clk.
//     - mem_we=1, mem_wzero=1, wptr counts 0..L-1.
//     - Then wptr=0 and the state moves to FILL.
//   - FILL: mem_we=ce. fill_cnt counts written samples.
//     - On the ce-cycle that fill_cnt reaches L-1, the state moves to RUN.
//   - RUN: mem_we=ce. Steady state.
//  out_valid: a RD_LATENCY-deep shift register clocked on ce.
//   - Its input is (state==RUN) in the base build.
//   - It is cleared on cfg_load and on rst.
//  cfg_load in any state (legal value):
//   - wptr and fill_cnt go to 0; out_valid clears next cycle.
//   - The state re-enters CLEAR or FILL.
//   - This takes priority over the ce update in the same cycle.
//  Simultaneous rst and cfg_load: rst wins and the state goes to IDLE.
//  busy = (state==CLEAR) | (state==FILL).
// CONFIGURATION
//  Macro RAM_DELAY_CTRL_ZERO_FILL_EN.
//   - Defined:
//     - The CLEAR state exists.
//     - The out_valid input is (state==FILL | state==RUN).
//     - Output is all zeros until the first real sample emerges, matching a reset FF delay line.
//     - The first data_out after CLEAR is valid cfg_delay ce-cycles after the FILL entry.
//   - Undefined:
//     - There is no CLEAR state; mem_wzero is tied to 0.
//     - out_valid stays low until RUN plus RD_LATENCY.
// TESTING
//  1. rst=1 for 2 cycles -> mem_we=0, out_valid=0, busy=0, state IDLE; ce pulses do not move wptr.
//  2. cfg_delay=100, cfg_load, ce=1 always, ramp data_in through a model BRAM
//     -> data_out[t] == data_in[t-100] for every valid cycle; wptr wraps 98->0 (RD_LATENCY=1).
//  3. Same as test 2 with ce toggling at random 50% -> delay is exactly 100 ce-cycles; no sample is lost or duplicated.
//  4. cfg_delay=2 -> cfg_err pulse, L unchanged. cfg_delay=MAX_DELAY -> accepted, wptr wraps at MAX_DELAY-RD_LATENCY-1.
//  5. Mid-RUN cfg_load with cfg_delay=10 -> out_valid drops next cycle, busy=1.
//     With the macro: 9 CLEAR cycles, and out_valid resumes immediately after CLEAR with data=0.
//     Without the macro: out_valid resumes after 10 ce-cycles.
//  6. rst asserted in the same cycle as cfg_load, mid-FILL -> IDLE, all outputs 0, cfg_err=0.

Source files
------------

// File: rtl/ram_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_delay_line_ctrl
// Description : Address/enable sequencer for a simple-dual-port READ_FIRST
//               BRAM used as a runtime-configurable delay line. A legal
//               cfg_load latches the ring length L = cfg_delay - RD_LATENCY
//               and restarts the line. A single shared address (wptr) is
//               presented to both ports, so each read returns the sample
//               written L ce-cycles earlier, and the BRAM output register
//               adds the remaining RD_LATENCY ce-cycles.
//               Optional feature macro: RAM_DELAY_CTRL_ZERO_FILL_EN
//               (adds a CLEAR state that zeroes the ring before FILL, so the
//               output behaves like a reset flip-flop delay line).
// Revision    : 1.0  initial release
// ============================================================================
module ram_delay_line_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_DELAY  = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [ADDR_WIDTH:0]   cfg_delay,
    input  logic                  cfg_load,
    output logic                  cfg_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  mem_wzero,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  out_valid,
    output logic                  busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_clear = 2'd1;
    localparam logic [1:0] c_st_fill  = 2'd2;
    localparam logic [1:0] c_st_run   = 2'd3;

    localparam logic [ADDR_WIDTH:0] c_min_delay = (ADDR_WIDTH+1)'(RD_LATENCY + 2);
    localparam logic [ADDR_WIDTH:0] c_max_delay = (ADDR_WIDTH+1)'(MAX_DELAY);
    localparam logic [ADDR_WIDTH:0] c_rd_lat    = (ADDR_WIDTH+1)'(RD_LATENCY);
    localparam logic [ADDR_WIDTH:0] c_one       = (ADDR_WIDTH+1)'(1);

`ifdef RAM_DELAY_CTRL_ZERO_FILL_EN
    // A restart first zeroes the whole ring.
    localparam logic [1:0] c_st_start = c_st_clear;
`else
    localparam logic [1:0] c_st_start = c_st_fill;
`endif

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH:0]   r_fill_cnt;
    logic [ADDR_WIDTH:0]   r_len;
    logic                  r_cfg_err;
    logic [RD_LATENCY-1:0] r_vpipe;

    logic                  w_cfg_ok;
    logic                  w_load_ok;
    logic [ADDR_WIDTH:0]   w_len_m1;
    logic                  w_wptr_last;
    logic [ADDR_WIDTH-1:0] w_wptr_next;
    logic                  w_valid_in;
    logic                  w_mem_we;

    assign w_cfg_ok    = (cfg_delay >= c_min_delay) && (cfg_delay <= c_max_delay);
    assign w_load_ok   = cfg_load && w_cfg_ok;
    assign w_len_m1    = r_len - c_one;
    // wptr never reaches L, so wrapping at L-1 keeps it inside the ring.
    assign w_wptr_last = ({1'b0, r_wptr} == w_len_m1);
    assign w_wptr_next = w_wptr_last ? '0 : r_wptr + ADDR_WIDTH'(1);

`ifdef RAM_DELAY_CTRL_ZERO_FILL_EN
    // Ring already holds zeros, so reads are meaningful from FILL onward.
    assign w_valid_in = (r_state == c_st_fill) || (r_state == c_st_run);
    assign mem_wzero  = (r_state == c_st_clear);
`else
    assign w_valid_in = (r_state == c_st_run);
    assign mem_wzero  = 1'b0;
`endif

    // Write enable: free-running in CLEAR, follows the stream in FILL/RUN.
    always_comb begin
        w_mem_we = 1'b0;
        case (r_state)
            c_st_clear:          w_mem_we = 1'b1;
            c_st_fill, c_st_run: w_mem_we = ce;
            default:             w_mem_we = 1'b0;
        endcase
    end

    assign mem_we    = w_mem_we;
    assign mem_re    = ce;
    assign mem_waddr = r_wptr;
    assign mem_raddr = r_wptr;
    assign busy      = (r_state == c_st_clear) || (r_state == c_st_fill);
    assign cfg_err   = r_cfg_err;
    assign out_valid = r_vpipe[RD_LATENCY-1];

    // Sequencer: restart on legal load, otherwise walk the ring.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_wptr     <= '0;
            r_fill_cnt <= '0;
            r_len      <= '0;
        end else if (w_load_ok) begin
            r_state    <= c_st_start;
            r_wptr     <= '0;
            r_fill_cnt <= '0;
            r_len      <= cfg_delay - c_rd_lat;
        end else begin
            case (r_state)
`ifdef RAM_DELAY_CTRL_ZERO_FILL_EN
                c_st_clear: begin
                    r_wptr <= w_wptr_next;
                    if (w_wptr_last) begin
                        r_state <= c_st_fill;
                    end
                end
`endif
                c_st_fill: begin
                    if (ce) begin
                        r_wptr     <= w_wptr_next;
                        r_fill_cnt <= r_fill_cnt + c_one;
                        // L-th write: the next read returns the first real sample.
                        if (r_fill_cnt == w_len_m1) begin
                            r_state <= c_st_run;
                        end
                    end
                end
                c_st_run: begin
                    if (ce) begin
                        r_wptr <= w_wptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Out-of-range request flag, one cycle per rejected load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_load && !w_cfg_ok;
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_vpipe_1
            // Valid tracks the BRAM output register, advanced on ce.
            always_ff @(posedge clk) begin
                if (rst || w_load_ok) begin
                    r_vpipe <= '0;
                end else if (ce) begin
                    r_vpipe[0] <= w_valid_in;
                end
            end
        end else begin : g_vpipe_n
            // Valid tracks the BRAM read pipeline, advanced on ce.
            always_ff @(posedge clk) begin
                if (rst || w_load_ok) begin
                    r_vpipe <= '0;
                end else if (ce) begin
                    r_vpipe <= {r_vpipe[RD_LATENCY-2:0], w_valid_in};
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire
